decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue.sv | 201 ++++++++++++++++++++
 tb/tb_decode_issue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: register file with write-through bypass, busy-bit
// scoreboard for RAW hazards, and a single-entry issue register feeding the ALU.
module decode_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic        alu_valid,
   input  logic        alu_ready,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rs2,
   output logic [11:0] imm12,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [4:0]  rd,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        illegal
);

   localparam logic [6:0] OP_R      = 7'd51;
   localparam logic [6:0] OP_IMM    = 7'd19;
   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JALR   = 7'd103;

   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];
   logic [31:0] busy_q, busy_d, busy_eff, wb_mask;

   logic        alu_valid_q, alu_valid_d;
   logic        illegal_q, illegal_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [6:0]  funct7_q, funct7_d;
   logic [4:0]  rs2_q, rs2_d;
   logic [11:0] imm12_q, imm12_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  rd_q, rd_d;

   logic [6:0]  in_op;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        supported, uses_rs2, sets_rd;
   logic [11:0] in_imm;
   logic        hazard, accept, issue;
   logic [31:0] rs1_val, rs2_val;

   assign in_op  = instr[6:0];
   assign in_rs1 = instr[19:15];
   assign in_rs2 = instr[24:20];
   assign in_rd  = instr[11:7];

   always_comb begin
      supported = 1'b0;
      uses_rs2  = 1'b0;
      sets_rd   = 1'b0;
      in_imm    = 12'd0;
      unique case (in_op)
         OP_R: begin
            supported = 1'b1;
            uses_rs2  = 1'b1;
            sets_rd   = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            supported = 1'b1;
            sets_rd   = 1'b1;
            in_imm    = instr[31:20];
         end
         OP_STORE: begin
            supported = 1'b1;
            uses_rs2  = 1'b1;
            in_imm    = {instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            supported = 1'b1;
            uses_rs2  = 1'b1;
            in_imm    = {instr[31], instr[7], instr[30:25], instr[11:8]};
         end
         default: ;
      endcase
   end

   // A writeback retiring this cycle already unblocks its dependents.
   assign wb_mask  = wb_en ? (32'd1 << wb_rd) : 32'd0;
   assign busy_eff = busy_q & ~wb_mask;

   always_comb begin
      hazard = 1'b0;
      if (instr_valid) begin
         if ((in_rs1 != 5'd0) && busy_eff[in_rs1])
            hazard = 1'b1;
         if (uses_rs2 && (in_rs2 != 5'd0) && busy_eff[in_rs2])
            hazard = 1'b1;
      end
   end

   assign instr_ready = rst_n && (!alu_valid_q || alu_ready) && !hazard;
   assign accept      = instr_valid && instr_ready;
   assign issue       = accept && supported;

   always_comb begin
      rs1_val = rf_q[in_rs1];
      rs2_val = rf_q[in_rs2];
      if (wb_en && (wb_rd == in_rs1))
         rs1_val = wb_data;
      if (wb_en && (wb_rd == in_rs2))
         rs2_val = wb_data;
      if (in_rs1 == 5'd0)
         rs1_val = 32'd0;
      if (in_rs2 == 5'd0)
         rs2_val = 32'd0;
   end

   always_comb begin
      rf_d = rf_q;
      if (wb_en && (wb_rd != 5'd0))
         rf_d[wb_rd] = wb_data;
   end

   // Set takes priority over the same-cycle writeback clear.
   always_comb begin
      busy_d = busy_eff;
      if (issue && sets_rd && (in_rd != 5'd0))
         busy_d[in_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      opcode_d    = opcode_q;
      funct3_d    = funct3_q;
      funct7_d    = funct7_q;
      rs2_d       = rs2_q;
      imm12_d     = imm12_q;
      a_d         = a_q;
      b_d         = b_q;
      rd_d        = rd_q;
      alu_valid_d = alu_valid_q && !alu_ready;
      illegal_d   = accept && !supported;
      if (issue) begin
         opcode_d    = in_op;
         funct3_d    = instr[14:12];
         funct7_d    = instr[31:25];
         rs2_d       = in_rs2;
         imm12_d     = in_imm;
         a_d         = rs1_val;
         b_d         = rs2_val;
         rd_d        = sets_rd ? in_rd : 5'd0;
         alu_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++)
            rf_q[i] <= 32'd0;
         busy_q      <= 32'd0;
         alu_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         opcode_q    <= 7'd0;
         funct3_q    <= 3'd0;
         funct7_q    <= 7'd0;
         rs2_q       <= 5'd0;
         imm12_q     <= 12'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         rd_q        <= 5'd0;
      end else begin
         for (int i = 0; i < 32; i++)
            rf_q[i] <= rf_d[i];
         busy_q      <= busy_d;
         alu_valid_q <= alu_valid_d;
         illegal_q   <= illegal_d;
         opcode_q    <= opcode_d;
         funct3_q    <= funct3_d;
         funct7_q    <= funct7_d;
         rs2_q       <= rs2_d;
         imm12_q     <= imm12_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rd_q        <= rd_d;
      end
   end

   assign alu_valid = alu_valid_q;
   assign illegal   = illegal_q;
   assign opcode    = opcode_q;
   assign funct3    = funct3_q;
   assign funct7    = funct7_q;
   assign rs2       = rs2_q;
   assign imm12     = imm12_q;
   assign a         = a_q;
   assign b         = b_q;
   assign rd        = rd_q;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: a reference model predicts readiness,
// scoreboard state and each issued instruction, queued until the ALU sees it.
module tb_decode_issue;

   logic        clk_sys;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        alu_valid;
   logic        alu_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs2;
   logic [11:0] imm12;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal;

   decode_issue dut (
      .clk         (clk_sys),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .rs2         (rs2),
      .imm12       (imm12),
      .a           (a),
      .b           (b),
      .rd          (rd),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .illegal     (illegal)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs2;
      logic [11:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
   } iss_t;

   iss_t        exp_q [$];
   logic [31:0] m_rf [32];
   logic [31:0] m_busy;
   logic        m_av;
   logic        m_ill;
   int          n_vec;
   int          n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_sup(input logic [6:0] op);
      return op inside {7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd103};
   endfunction

   function automatic logic [11:0] m_imm(input logic [31:0] i);
      case (i[6:0])
         7'd19, 7'd3, 7'd103: return i[31:20];
         7'd35:               return {i[31:25], i[11:7]};
         7'd99:               return {i[31], i[7], i[30:25], i[11:8]};
         default:             return 12'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_en && wb_rd == idx) return wb_data;
      return m_rf[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_busy = 32'd0;
      m_av   = 1'b0;
      m_ill  = 1'b0;
      exp_q.delete();
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic tick();
      logic [31:0] beff;
      logic [6:0]  op;
      logic [4:0]  r1, r2, rdst;
      logic        use2, hz, exp_rdy, acc, sup;
      iss_t        e;
      #1;
      op   = instr[6:0];
      r1   = instr[19:15];
      r2   = instr[24:20];
      rdst = instr[11:7];
      sup  = m_sup(op);
      use2 = op inside {7'd51, 7'd35, 7'd99};
      beff = m_busy;
      if (wb_en) beff[wb_rd] = 1'b0;
      hz = instr_valid && (((r1 != 0) && beff[r1]) || (use2 && (r2 != 0) && beff[r2]));
      exp_rdy = (!m_av || alu_ready) && !hz;
      chk("instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
      acc = instr_valid && exp_rdy;
      if (m_av && alu_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc && sup) begin
         e.op  = op;
         e.f3  = instr[14:12];
         e.f7  = instr[31:25];
         e.rs2 = r2;
         e.imm = m_imm(instr);
         e.a   = m_read(r1);
         e.b   = m_read(r2);
         e.rd  = (op == 7'd35 || op == 7'd99) ? 5'd0 : rdst;
         exp_q.push_back(e);
      end
      m_av  = (acc && sup) ? 1'b1 : (alu_ready ? 1'b0 : m_av);
      m_ill = acc && !sup;
      m_busy = beff;
      if (acc && sup && !(op == 7'd35 || op == 7'd99) && rdst != 0) m_busy[rdst] = 1'b1;
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
      @(posedge clk_sys);
      #1;
      chk("alu_valid", {31'd0, alu_valid}, {31'd0, m_av});
      chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
      chk("busy", dut.busy_q, m_busy);
      if (m_av) begin
         if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            e = exp_q[0];
            chk("opcode", {25'd0, opcode}, {25'd0, e.op});
            chk("funct3", {29'd0, funct3}, {29'd0, e.f3});
            chk("funct7", {25'd0, funct7}, {25'd0, e.f7});
            chk("rs2", {27'd0, rs2}, {27'd0, e.rs2});
            chk("imm12", {20'd0, imm12}, {20'd0, e.imm});
            chk("a", a, e.a);
            chk("b", b, e.b);
            chk("rd", {27'd0, rd}, {27'd0, e.rd});
         end
      end
      @(negedge clk_sys);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic ar,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
      instr_valid = v;
      instr       = ins;
      alu_ready   = ar;
      wb_en       = we;
      wb_rd       = wr;
      wb_data     = wd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_valid"}, {31'd0, alu_valid}, 32'd0);
      chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
      chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd0);
      chk({tag, "_fields"}, {opcode, funct3, funct7, rs2, imm12 != 0, rd != 0}, 32'd0);
      chk({tag, "_a"}, a, 32'd0);
      chk({tag, "_b"}, b, 32'd0);
      chk({tag, "_busy"}, dut.busy_q, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      rst_n = 1'b0;
      drive(1'b1, 32'h002081B3, 1'b1, 1'b1, 5'd1, 32'd9);
      repeat (2) @(negedge clk_sys);
      chk_all_zero("reset");
      rst_n = 1'b1;
      drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5);
      tick();
      drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd7);
      tick();
      drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'd99);
      tick();

      // add x3,x1,x2
      drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("add_valid", {31'd0, alu_valid}, 32'd1);
      chk("add_op", {25'd0, opcode}, 32'd51);
      chk("add_a", a, 32'd5);
      chk("add_b", b, 32'd7);
      chk("add_rd", {27'd0, rd}, 32'd3);
      chk("add_busy3", {31'd0, dut.busy_q[3]}, 32'd1);

      // addi x4,x3,1 stalls on x3 until its writeback arrives
      drive(1'b1, 32'h00118213, 1'b1, 1'b0, 5'd0, 32'd0);
      #1 chk("addi_stall", {31'd0, instr_ready}, 32'd0);
      tick();
      drive(1'b1, 32'h00118213, 1'b1, 1'b1, 5'd3, 32'd12);
      #1 chk("addi_go", {31'd0, instr_ready}, 32'd1);
      tick();
      chk("addi_a", a, 32'd12);
      chk("addi_imm", {20'd0, imm12}, 32'd1);

      // sw x2,8(x1)
      drive(1'b1, 32'h0020A423, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("sw_imm", {20'd0, imm12}, 32'd8);
      chk("sw_rd", {27'd0, rd}, 32'd0);
      chk("sw_b", b, 32'd7);
      chk("sw_busy", dut.busy_q, 32'h0000_0010);

      // beq x1,x2,-4
      drive(1'b1, 32'hFE208EE3, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("beq_imm", {20'd0, imm12}, 32'hFFE);

      // ALU stall for three cycles with add x5 waiting, then back-to-back
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h002082B3, 1'b0, 1'b0, 5'd0, 32'd0);
         tick();
         chk("stall_imm", {20'd0, imm12}, 32'hFFE);
         chk("stall_valid", {31'd0, alu_valid}, 32'd1);
      end
      drive(1'b1, 32'h002082B3, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("b2b_rd5", {27'd0, rd}, 32'd5);
      drive(1'b1, 32'h00208333, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("b2b_rd6", {27'd0, rd}, 32'd6);
      chk("b2b_valid", {31'd0, alu_valid}, 32'd1);

      // write to x0 ignored; add x8,x0,x0 also retires x6 and x4
      drive(1'b1, 32'h00000433, 1'b1, 1'b1, 5'd6, 32'd66);
      tick();
      drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd4, 32'd44);
      tick();

      // unsupported opcode
      drive(1'b1, 32'h0000007F, 1'b1, 1'b1, 5'd8, 32'd88);
      tick();
      chk("ill_pulse", {31'd0, illegal}, 32'd1);
      chk("ill_valid", {31'd0, alu_valid}, 32'd0);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("ill_clear", {31'd0, illegal}, 32'd0);

      // randomised traffic through the model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ins;
         logic [6:0]  ops [7];
         ops = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd103, 7'h0B};
         ins = $urandom();
         ins[6:0] = ops[$urandom_range(0, 6)];
         drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom());
         tick();
      end

      // reset during a stall with an instruction pending
      drive(1'b1, 32'h002083B3, 1'b0, 1'b1, 5'd7, 32'd1);
      tick();
      drive(1'b1, 32'h00138433, 1'b0, 1'b0, 5'd0, 32'd0);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      model_reset();
      @(negedge clk_sys);
      rst_n = 1'b1;
      drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("post_rst_a", a, 32'd0);
      chk("post_rst_b", b, 32'd0);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
